fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter HALT_OPC, default 4'hF, opcode in instr[15:12] that identifies HLT.
REQ-002 Parameter NOP_INSTR, default 16'h0000, encoding injected into IF/ID on a bubble or flush.
REQ-003 Parameter DRAIN_CYCLES, default 3, cycles waited after HLT fetch before declaring halted.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 pc  input  16  current PC, from the PC register.
REQ-007 imem_data  input  16  instruction at pc, combinational read from instruction memory.
REQ-008 stall  input  1  hazard unit: hold PC and IF/ID.
REQ-009 branch_taken  input  1  resolved taken branch or jump: redirect and flush.
REQ-010 branch_target  input  16  redirect address, valid when branch_taken=1.
REQ-011 next_pc  output  16  value to load into the PC register.
REQ-012 pc_en  output  1  write enable for the PC register.
REQ-013 ifid_instr  output  16  registered IF/ID instruction.
REQ-014 ifid_pc_plus2  output  16  registered pc+2 of that instruction.
REQ-015 ifid_valid  output  1  registered: IF/ID holds a real instruction.
REQ-016 halted  output  1  registered: fetch permanently stopped.

Function
REQ-017 pc_plus2 SHALL be pc+16'd2 modulo 2^16; 16'hFFFE SHALL wrap to 16'h0000.
REQ-018 next_pc SHALL be branch_target when branch_taken=1, else pc_plus2.
REQ-019 FSM states SHALL be RUN, DRAIN, HALTED.
REQ-020 In RUN, pc_en SHALL be 1 when branch_taken=1 or stall=0, and 0 otherwise.
REQ-021 In RUN with branch_taken=1, IF/ID SHALL load NOP_INSTR with ifid_valid=0; branch_taken SHALL take priority over stall.
REQ-022 In RUN with stall=1 and branch_taken=0, IF/ID SHALL hold its contents unchanged.
REQ-023 In RUN with neither stall nor branch_taken, IF/ID SHALL load imem_data, pc_plus2 and valid=1.
REQ-024 When RUN loads an instruction with imem_data[15:12]=HALT_OPC, the instruction SHALL enter IF/ID normally, the FSM SHALL go to DRAIN, and the drain counter SHALL clear to 0.
REQ-025 In DRAIN, pc_en SHALL be 0 unless branch_taken=1; the IF/ID input SHALL be NOP_INSTR with valid=0, subject to stall hold.
REQ-026 In DRAIN with branch_taken=1, the HLT SHALL be treated as wrong-path: pc_en=1, next_pc=branch_target, IF/ID flushed, FSM returns to RUN.
REQ-027 In DRAIN without branch_taken, the counter SHALL increment only when stall=0; at count DRAIN_CYCLES-1 it SHALL go to HALTED.
REQ-028 HALTED SHALL be absorbing until reset: pc_en=0, IF/ID=NOP/invalid, halted=1, branch_taken ignored.
REQ-029 The drain counter SHALL be 2 bits wide, sufficient for DRAIN_CYCLES<=4.

Reset
REQ-030 When rst_n=0, the block SHALL asynchronously force state=RUN, counter=0, ifid_instr=NOP_INSTR, ifid_pc_plus2=16'h0000, ifid_valid=0 and halted=0.
REQ-031 While rst_n=0, pc_en SHALL be 0.
REQ-032 Reset asserted mid-DRAIN or in HALTED SHALL return the block to RUN, with fetch resuming on the first edge after rst_n rises.

Structure
REQ-033 The FSM state enum, HALT_OPC and NOP_INSTR defaults SHALL live in the shared CPU package.
REQ-034 The IF/ID register SHALL be a sub-module ifid_reg (instr, pc_plus2, valid; write enable, flush, async reset).
REQ-035 All other logic, including next-PC mux, FSM and counter, SHALL reside in fetch_stage.

Verification
REQ-036 Reset, then pc=16'h0000 and imem_data=16'h1234 with no stall -> next_pc=16'h0002, pc_en=1; after the edge, ifid_instr=16'h1234, ifid_pc_plus2=16'h0002, ifid_valid=1.
REQ-037 pc=16'hFFFE -> next_pc=16'h0000.
REQ-038 stall=1 and branch_taken=1 with branch_target=16'h0040 -> pc_en=1, next_pc=16'h0040; after the edge, ifid_valid=0 and ifid_instr=NOP_INSTR.
REQ-039 stall=1 for 2 cycles -> pc_en=0 and IF/ID unchanged for both cycles.
REQ-040 imem_data=16'hF000 with no branch -> halted=1 exactly 4 edges after the fetch edge (1 fetch edge + 3 drain edges), and pc_en=0 throughout the drain.
REQ-041 16'hF000 fetched, then branch_taken=1 with target 16'h0100 in the next cycle -> back to RUN, next_pc=16'h0100, halted stays 0.
REQ-042 rst_n pulled low while halted=1 -> halted=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: FSM states and default encodings.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   localparam logic [3:0]  HALT_OPC_DEF  = 4'hF;
   localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

   function automatic logic is_halt(input logic [15:0] instr, input logic [3:0] opc);
      return instr[15:12] == opc;
   endfunction

endpackage

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register: flush loads a bubble, write enable loads a fetched instruction.
module ifid_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic        flush,
   input  logic [15:0] instr_d,
   input  logic [15:0] pc_plus2_d,
   output logic [15:0] instr,
   output logic [15:0] pc_plus2,
   output logic        valid
);

   // Flush wins over write enable so a redirect can never let a wrong-path instruction through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr    <= NOP_INSTR;
         pc_plus2 <= 16'h0000;
         valid    <= 1'b0;
      end else if (flush) begin
         instr    <= NOP_INSTR;
         pc_plus2 <= 16'h0000;
         valid    <= 1'b0;
      end else if (we) begin
         instr    <= instr_d;
         pc_plus2 <= pc_plus2_d;
         valid    <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: next-PC selection, IF/ID control and the HLT drain/halt state machine.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [3:0]  HALT_OPC     = HALT_OPC_DEF,
   parameter logic [15:0] NOP_INSTR    = NOP_INSTR_DEF,
   parameter int          DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pc,
   input  logic [15:0] imem_data,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   output logic [15:0] next_pc,
   output logic        pc_en,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc_plus2,
   output logic        ifid_valid,
   output logic        halted
);

   localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

   fetch_state_e state;
   logic [1:0]   drain_cnt;
   logic [15:0]  pc_plus2;
   logic         ifid_we;
   logic         ifid_flush;
   logic         load_hlt;

   assign pc_plus2 = pc + 16'd2;
   assign next_pc  = branch_taken ? branch_target : pc_plus2;
   assign load_hlt = (state == RUN) && !branch_taken && !stall && is_halt(imem_data, HALT_OPC);

   always_comb begin
      pc_en      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b0;
      case (state)
         RUN: begin
            pc_en      = branch_taken || !stall;
            ifid_flush = branch_taken;
            ifid_we    = !branch_taken && !stall;
         end
         DRAIN: begin
            // Bubbles follow the HLT; a stall still holds whatever IF/ID contains.
            pc_en      = branch_taken;
            ifid_flush = branch_taken || !stall;
         end
         HALTED: begin
            ifid_flush = 1'b1;
         end
         default: begin
            pc_en = 1'b0;
         end
      endcase
      if (!rst_n) pc_en = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         drain_cnt <= 2'd0;
         halted    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (load_hlt) begin
                  state     <= DRAIN;
                  drain_cnt <= 2'd0;
               end
            end
            DRAIN: begin
               // A taken branch means the HLT was on the wrong path.
               if (branch_taken) begin
                  state <= RUN;
               end else if (!stall) begin
                  if (drain_cnt == DRAIN_LAST) begin
                     state  <= HALTED;
                     halted <= 1'b1;
                  end else begin
                     drain_cnt <= drain_cnt + 2'd1;
                  end
               end
            end
            HALTED: begin
               halted <= 1'b1;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
      .clk        (clk),
      .rst_n      (rst_n),
      .we         (ifid_we),
      .flush      (ifid_flush),
      .instr_d    (imem_data),
      .pc_plus2_d (pc_plus2),
      .instr      (ifid_instr),
      .pc_plus2   (ifid_pc_plus2),
      .valid      (ifid_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: PC mux, stall/flush behaviour, HLT drain and reset.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic [15:0] pc;
   logic [15:0] imem_data;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic [15:0] next_pc;
   logic        pc_en;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc_plus2;
   logic        ifid_valid;
   logic        halted;

   int n_checks = 0;
   int n_errors = 0;

   fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc            (pc),
      .imem_data     (imem_data),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .next_pc       (next_pc),
      .pc_en         (pc_en),
      .ifid_instr    (ifid_instr),
      .ifid_pc_plus2 (ifid_pc_plus2),
      .ifid_valid    (ifid_valid),
      .halted        (halted)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one rising edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] p, input logic [15:0] d, input logic s,
                        input logic b, input logic [15:0] t);
      pc            = p;
      imem_data     = d;
      stall         = s;
      branch_taken  = b;
      branch_target = t;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(16'h0000, 16'h1234, 1'b0, 1'b0, 16'h0000);
      #2;
      check("rst_pc_en",    16'(pc_en), 16'h0000);
      check("rst_valid",    16'(ifid_valid), 16'h0000);
      check("rst_instr",    ifid_instr, 16'h0000);
      check("rst_pc_plus2", ifid_pc_plus2, 16'h0000);
      check("rst_halted",   16'(halted), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // plain fetch
      check("f1_next_pc", next_pc, 16'h0002);
      check("f1_pc_en",   16'(pc_en), 16'h0001);
      step();
      check("f1_instr",    ifid_instr, 16'h1234);
      check("f1_pc_plus2", ifid_pc_plus2, 16'h0002);
      check("f1_valid",    16'(ifid_valid), 16'h0001);

      // wrap at top of address space
      drive(16'hFFFE, 16'h2222, 1'b0, 1'b0, 16'h0000);
      check("wrap_next_pc", next_pc, 16'h0000);
      step();
      check("wrap_instr",    ifid_instr, 16'h2222);
      check("wrap_pc_plus2", ifid_pc_plus2, 16'h0000);

      // two-cycle stall holds PC and IF/ID
      drive(16'h0004, 16'h3333, 1'b1, 1'b0, 16'h0000);
      for (int i = 0; i < 2; i++) begin
         check("stall_pc_en", 16'(pc_en), 16'h0000);
         step();
         check("stall_instr",    ifid_instr, 16'h2222);
         check("stall_pc_plus2", ifid_pc_plus2, 16'h0000);
         check("stall_valid",    16'(ifid_valid), 16'h0001);
      end

      // branch beats stall
      drive(16'h0004, 16'h3333, 1'b1, 1'b1, 16'h0040);
      check("br_pc_en",   16'(pc_en), 16'h0001);
      check("br_next_pc", next_pc, 16'h0040);
      step();
      check("br_valid", 16'(ifid_valid), 16'h0000);
      check("br_instr", ifid_instr, 16'h0000);

      // HLT fetch then drain to halted
      drive(16'h0010, 16'hF000, 1'b0, 1'b0, 16'h0000);
      check("hlt_pc_en_fetch", 16'(pc_en), 16'h0001);
      step();
      check("hlt_instr",  ifid_instr, 16'hF000);
      check("hlt_valid",  16'(ifid_valid), 16'h0001);
      check("hlt_halted", 16'(halted), 16'h0000);
      drive(16'h0012, 16'h5555, 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         check("drain_pc_en", 16'(pc_en), 16'h0000);
         check("drain_halted_pre", 16'(halted), 16'h0000);
         step();
         check("drain_valid", 16'(ifid_valid), 16'h0000);
      end
      check("drain_halted", 16'(halted), 16'h0001);

      // halted ignores branches
      drive(16'h0012, 16'h5555, 1'b0, 1'b1, 16'h0080);
      check("halt_br_pc_en", 16'(pc_en), 16'h0000);
      step();
      check("halt_br_halted", 16'(halted), 16'h0001);
      check("halt_br_valid",  16'(ifid_valid), 16'h0000);

      // asynchronous reset out of HALTED, away from any edge
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_halted", 16'(halted), 16'h0000);
      check("arst_pc_en",  16'(pc_en), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // HLT on the wrong path is cancelled by a branch during drain
      drive(16'h0020, 16'hF000, 1'b0, 1'b0, 16'h0000);
      check("rsm_pc_en", 16'(pc_en), 16'h0001);
      step();
      check("wp_hlt_valid", 16'(ifid_valid), 16'h0001);
      drive(16'h0022, 16'h5555, 1'b0, 1'b1, 16'h0100);
      check("wp_pc_en",   16'(pc_en), 16'h0001);
      check("wp_next_pc", next_pc, 16'h0100);
      step();
      check("wp_valid", 16'(ifid_valid), 16'h0000);
      drive(16'h0100, 16'h1111, 1'b0, 1'b0, 16'h0000);
      check("wp_run_pc_en",   16'(pc_en), 16'h0001);
      check("wp_run_next_pc", next_pc, 16'h0102);
      step();
      check("wp_run_instr", ifid_instr, 16'h1111);
      check("wp_run_valid", 16'(ifid_valid), 16'h0001);
      for (int i = 0; i < 4; i++) step();
      check("wp_halted", 16'(halted), 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
